stream_arb_mux: RTL
===================

# stream_arb_mux

Parametrised N-channel, valid/ready stream multiplexer with a registered output stage and selectable arbitration: fixed priority, round-robin, or forced select. It is the sequential successor of the team's WIDTH-parametrised 2:1 mux. It merges several producer streams into one consumer stream without dropping or duplicating beats.

## Interface
- WIDTH, 8, data width per channel (≥1)
- NUM_CH, 4, number of input channels (≥2); CH_W = $clog2(NUM_CH)
- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  synchronous, active-low reset
- mode_i  in  2  arbitration mode: 0 fixed priority, 1 round-robin, 2 forced select, 3 treated as round-robin
- sel_i  in  CH_W  channel index used in forced mode
- in_valid_i  in  NUM_CH  per-channel valid
- in_data_i  in  NUM_CH*WIDTH  channel c data at [c*WIDTH +: WIDTH]
- in_ready_o  out  NUM_CH  per-channel ready; one-hot or zero
- out_valid_o  out  1  registered output valid
- out_data_o  out  WIDTH  registered output data
- out_ch_o  out  CH_W  source channel of the current output beat
- out_ready_i  in  1  consumer ready

## Operation
- Output register state: EMPTY (out_valid_o=0) or FULL (out_valid_o=1). Transfer occurs on any edge with valid && ready.
- load = !out_valid_o || out_ready_i. A grant is made only when load=1.
- Eligible set: in_valid_i, further restricted by mode.
  - Fixed priority: lowest eligible index wins.
  - Round-robin: first eligible index at or after rr_ptr, wrapping modulo NUM_CH.
  - Forced: only channel sel_i is eligible. If sel_i ≥ NUM_CH, nothing is granted.
- in_ready_o[g]=1 only for the granted channel g, and only while load=1. All other bits are 0.
- On a grant: out_data_o ← channel g data, out_ch_o ← g, out_valid_o ← 1.
- On load=1 with no grant: out_valid_o ← 0. out_data_o and out_ch_o hold their values.
- rr_ptr ← (g+1) mod NUM_CH after every grant, in any mode. rr_ptr holds when there is no grant. Wrap from NUM_CH-1 goes to 0.
- Non-power-of-2 NUM_CH: indices ≥ NUM_CH are never granted.
- mode_i and sel_i are sampled combinationally each cycle. A change affects the next grant only; the beat already in the output register is never altered.
- Data is never modified, truncated or re-ordered within a channel.

## Timing
- Latency: input accept edge to out_valid_o is 1 cycle.
- Full throughput: one beat per cycle while out_ready_i=1 and any channel is eligible.
- in_ready_o has a combinational path from out_ready_i, in_valid_i, mode_i and sel_i. It does not depend on in_data_i.
- Backpressure: when out_valid_o=1 and out_ready_i=0, the output holds stable and all in_ready_o are 0.
- Simultaneous output drain and new grant: the output takes the new beat in the same edge, with no bubble.
- Reset values (reset_n=0 sampled at the edge):
  - out_valid_o=0, out_data_o=0, out_ch_o=0, rr_ptr=0.
  - in_ready_o is forced to 0 combinationally while reset_n=0.
- Reset mid-transfer: the beat held in the output register is discarded. No in_ready_o pulse occurs during the reset cycle.

## Structure
- Package stream_arb_mux_pkg:
  - typedef enum logic [1:0] arb_mode_e {ARB_FIXED, ARB_RR, ARB_FORCE, ARB_RSVD}
  - function ch_w(n) returning $clog2(n)
- Sub-module rr_arbiter #(NUM_CH):
  - inputs: req, ptr, fixed
  - outputs: one-hot grant, encoded index, any
  - pure combinational masked priority pick
- Top: eligibility mask, output register, rr_ptr register.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with all in_valid_i=1 and out_ready_i=1 -> in_ready_o=0, out_valid_o=0, out_data_o=0, out_ch_o=0.
- Round-robin fairness: NUM_CH=4, all channels valid, data[c]=8'h10+c, out_ready_i=1 -> out_ch_o sequence 0,1,2,3,0 on consecutive cycles with data 10,11,12,13,10.
- Fixed priority: mode 0, channels 1 and 3 valid -> channel 1 is granted every cycle and channel 3 starves. Deassert ch1 -> ch3 is granted the next cycle.
- Forced select:
  - mode 2, sel_i=2, all valid, data[2]=8'hAA -> only in_ready_o=4'b0100 and out_data_o=AA.
  - sel_i=2 with ch2 invalid -> out_valid_o drops to 0 the next cycle.
- Backpressure: out_ready_i=0 for 3 cycles while holding beat 8'h55 -> out_data_o stays 55 and in_ready_o=0. Release -> 55 is accepted and the next beat loads in the same edge.
- Mid-stream reset: assert reset_n=0 while out_valid_o=1 -> out_valid_o=0 the next cycle. After release, the first grant in RR mode goes to the lowest valid channel (rr_ptr=0).

Source files
------------

// File: rtl/stream_arb_mux_pkg.sv
// Shared types and helpers for the stream_arb_mux block.
// Arbitration mode encoding and channel-index width helper.
package stream_arb_mux_pkg;

  typedef enum logic [1:0] {
    ARB_FIXED = 2'd0,
    ARB_RR    = 2'd1,
    ARB_FORCE = 2'd2,
    ARB_RSVD  = 2'd3
  } arb_mode_e;

  function automatic int ch_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/stream_arb_mux_if.sv
// Valid/ready bundle between NUM_CH producers, the mux, and one consumer.
// Signal suffixes are from the mux's point of view (slave modport).
interface stream_arb_mux_if
  import stream_arb_mux_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
);
  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0]       in_valid_i;
  logic [NUM_CH*WIDTH-1:0] in_data_i;
  logic [NUM_CH-1:0]       in_ready_o;
  logic                    out_valid_o;
  logic [WIDTH-1:0]        out_data_o;
  logic [CH_W-1:0]         out_ch_o;
  logic                    out_ready_i;

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_ch_o
  );

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_ch_o
  );

endinterface

// File: rtl/stream_arb_mux_rr_arbiter.sv
// Combinational masked priority picker: first request at or after ptr_i,
// wrapping; fixed_i forces the search to start at index 0.
module rr_arbiter
  import stream_arb_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int CH_W  = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  input  logic              fixed_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [CH_W-1:0]   idx_o,
  output logic              any_o
);

  logic [CH_W-1:0] start;

  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    start   = fixed_i ? '0 : ptr_i;
    // Upper pass covers [start, NUM_CH-1]; the lower pass supplies the wrap.
    for (int c = 0; c < NUM_CH; c++) begin
      if (!any_o && req_i[c] && (CH_W'(c) >= start)) begin
        any_o      = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = CH_W'(c);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!any_o && req_i[c]) begin
        any_o      = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-channel valid/ready stream mux with a registered output stage and
// fixed-priority, round-robin or forced-select arbitration.
module stream_arb_mux
  import stream_arb_mux_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  localparam int CH_W  = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mode_i,
  input  logic [CH_W-1:0]   sel_i,
  stream_arb_mux_if.slave   bus
);

  arb_mode_e         mode;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_any;
  logic [WIDTH-1:0]  grant_data;
  logic              load;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [CH_W-1:0]   out_ch_q,    out_ch_d;
  logic [CH_W-1:0]   rr_ptr_q,    rr_ptr_d;

  assign mode = arb_mode_e'(mode_i);
  assign load = !out_valid_q || bus.out_ready_i;

  // Forced mode: an out-of-range sel_i matches no channel, so nothing is eligible.
  always_comb begin
    eligible = bus.in_valid_i;
    if (mode == ARB_FORCE) begin
      eligible = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (sel_i == CH_W'(c)) eligible[c] = bus.in_valid_i[c];
      end
    end
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .fixed_i (mode == ARB_FIXED),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  always_comb begin
    grant_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) grant_data = bus.in_data_i[c*WIDTH +: WIDTH];
    end
  end

  assign bus.in_ready_o = (reset_n && load) ? grant : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      if (grant_any) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_data;
        out_ch_d    = grant_idx;
        rr_ptr_d    = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_ch_o    = out_ch_q;

endmodule
